// File: rtl/fixpoint_pkg.sv
// Shared types and defaults for the fixpoint iteration controller.
//   state_e     : controller FSM states
//   outcome_e   : evaluation outcome encoding
//   res_flags_t : one-hot result flags presented on the result port
package fixpoint_pkg;

  localparam int unsigned DEF_W        = 10;
  localparam int unsigned DEF_MAX_ITER = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OUT_NONE    = 2'd0,
    OUT_FIX     = 2'd1,
    OUT_BUG     = 2'd2,
    OUT_TIMEOUT = 2'd3
  } outcome_e;

  typedef struct packed {
    logic fix;
    logic bug;
    logic timeout;
  } res_flags_t;

  // Outcome to one-hot result flags.
  function automatic res_flags_t decode_outcome(input outcome_e o);
    res_flags_t f;
    f = '0;
    case (o)
      OUT_FIX:     f.fix     = 1'b1;
      OUT_BUG:     f.bug     = 1'b1;
      OUT_TIMEOUT: f.timeout = 1'b1;
      default:     f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fixpoint_step.sv
// Monotone one-step state transition: each bit is set by itself or by its
// upper neighbour (inj feeds the MSB) unless blocked by blk.
//   cur    : current state
//   blk    : per-bit block mask
//   inj    : injection bit into the MSB
//   nxt_c  : combinational next state
module fixpoint_step #(
  parameter int unsigned W = 10
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] blk,
  input  logic         inj,
  output logic [W-1:0] nxt_c
);

  // Upper-neighbour vector {inj, cur[W-1:1]} lines bit i+1 up with bit i.
  assign nxt_c = cur | ({inj, cur[W-1:1]} & ~blk);

endmodule

// File: rtl/fixpoint_iter_ctrl.sv
// Iterative fixpoint controller: loads an initial state, applies the step
// once per cycle, checks each visited state against a bad mask and reports
// fix / bug / timeout with the iteration count over a valid/ready port.
//   clk, rst_n            : clock, async active-low reset
//   start                 : request pulse, accepted only in IDLE
//   init, blk, inj, bad   : operands, sampled with start
//   busy                  : high in EVAL and DONE
//   res_valid, res_ready  : result handshake
//   res_fix/bug/timeout   : one-hot outcome while res_valid
//   res_iter, res_state   : step count and final state
module fixpoint_iter_ctrl
  import fixpoint_pkg::*;
#(
  parameter  int unsigned W        = DEF_W,
  parameter  int unsigned MAX_ITER = DEF_MAX_ITER,
  localparam int unsigned CNT_W    = $clog2(MAX_ITER + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     init,
  input  logic [W-1:0]     blk,
  input  logic             inj,
  input  logic [W-1:0]     bad,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_fix,
  output logic             res_bug,
  output logic             res_timeout,
  output logic [CNT_W-1:0] res_iter,
  output logic [W-1:0]     res_state
);

  state_e           state_q, state_d;
  logic [W-1:0]     cur_q, cur_d;
  logic [W-1:0]     blk_q, blk_d;
  logic             inj_q, inj_d;
  logic [W-1:0]     bad_q, bad_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  res_flags_t       flags_q, flags_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  outcome_e         outcome;
  logic [W-1:0]     nxt_c;

  fixpoint_step #(.W(W)) u_step (
    .cur   (cur_q),
    .blk   (blk_q),
    .inj   (inj_q),
    .nxt_c (nxt_c)
  );

  // Next-state, operand capture, iteration and result decision.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    blk_d   = blk_q;
    inj_d   = inj_q;
    bad_d   = bad_q;
    iter_d  = iter_q;
    flags_d = flags_q;
    outcome = OUT_NONE;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_d   = init;
          blk_d   = blk;
          inj_d   = inj;
          bad_d   = bad;
          iter_d  = '0;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        // Bug outranks fix, fix outranks timeout.
        if ((cur_q & bad_q) != '0) begin
          outcome = OUT_BUG;
        end else if (nxt_c == cur_q) begin
          outcome = OUT_FIX;
        end else if (iter_q == CNT_W'(MAX_ITER)) begin
          outcome = OUT_TIMEOUT;
        end else begin
          cur_d  = nxt_c;
          iter_d = iter_q + CNT_W'(1);
        end
        if (outcome != OUT_NONE) begin
          flags_d = decode_outcome(outcome);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          flags_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_DONE);
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      blk_q   <= '0;
      inj_q   <= 1'b0;
      bad_q   <= '0;
      iter_q  <= '0;
      flags_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      blk_q   <= blk_d;
      inj_q   <= inj_d;
      bad_q   <= bad_d;
      iter_q  <= iter_d;
      flags_q <= flags_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  // cur/iter are frozen in DONE, so they double as the result payload.
  assign busy        = busy_q;
  assign res_valid   = valid_q;
  assign res_fix     = flags_q.fix;
  assign res_bug     = flags_q.bug;
  assign res_timeout = flags_q.timeout;
  assign res_iter    = iter_q;
  assign res_state   = cur_q;

endmodule

// File: tb/tb_fixpoint_iter_ctrl.sv
// Self-checking bench for fixpoint_iter_ctrl: table vectors plus random
// vectors through a scoreboard, and directed sequences for timeout,
// backpressure and asynchronous reset.
module tb_fixpoint_iter_ctrl;

  localparam int unsigned W    = 10;
  localparam int unsigned MI   = 16;
  localparam int unsigned MIB  = 4;
  localparam int unsigned CW   = $clog2(MI + 1);
  localparam int unsigned CWB  = $clog2(MIB + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, start_b;
  logic [W-1:0]  init, blk, bad;
  logic          inj;
  logic          res_ready;

  logic          a_busy, a_valid, a_fix, a_bug, a_tmo;
  logic [CW-1:0] a_iter;
  logic [W-1:0]  a_state;
  logic          b_busy, b_valid, b_fix, b_bug, b_tmo;
  logic [CWB-1:0] b_iter;
  logic [W-1:0]  b_state;

  always #5 clk = ~clk;

  fixpoint_iter_ctrl #(.W(W), .MAX_ITER(MI)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init(init), .blk(blk),
    .inj(inj), .bad(bad), .busy(a_busy), .res_valid(a_valid),
    .res_ready(res_ready), .res_fix(a_fix), .res_bug(a_bug),
    .res_timeout(a_tmo), .res_iter(a_iter), .res_state(a_state)
  );

  fixpoint_iter_ctrl #(.W(W), .MAX_ITER(MIB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .init(init), .blk(blk),
    .inj(inj), .bad(bad), .busy(b_busy), .res_valid(b_valid),
    .res_ready(res_ready), .res_fix(b_fix), .res_bug(b_bug),
    .res_timeout(b_tmo), .res_iter(b_iter), .res_state(b_state)
  );

  typedef struct {
    logic [W-1:0] init;
    logic [W-1:0] blk;
    logic         inj;
    logic [W-1:0] bad;
    logic         fix;
    logic         bug;
    logic         tmo;
    int           iter;
    logic [W-1:0] st;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[10];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // Reference iteration written bit by bit from the step definition.
  function automatic vec_t model(input vec_t v, input int maxit);
    vec_t         r;
    logic [W-1:0] cur, nx;
    int           it;
    r = v; r.fix = 1'b0; r.bug = 1'b0; r.tmo = 1'b0;
    cur = v.init; it = 0;
    for (int g = 0; g <= maxit + 1; g++) begin
      for (int i = 0; i < W; i++) begin
        logic up;
        if (i == W - 1) up = v.inj; else up = cur[i+1];
        nx[i] = cur[i] | (up & ~v.blk[i]);
      end
      if ((cur & v.bad) != '0) begin r.bug = 1'b1; break; end
      if (nx == cur)            begin r.fix = 1'b1; break; end
      if (it == maxit)          begin r.tmo = 1'b1; break; end
      cur = nx; it++;
    end
    r.iter = it; r.st = cur;
    return r;
  endfunction

  // Entered and left at a negedge; operands scrambled after acceptance.
  task automatic launch(input vec_t v, input bit push);
    init = v.init; blk = v.blk; inj = v.inj; bad = v.bad; start = 1'b1;
    if (push) exp_q.push_back(v);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    init = W'($urandom); blk = W'($urandom); inj = 1'($urandom); bad = W'($urandom);
  endtask

  task automatic await_result();
    vec_t e;
    int   n = 0;
    do begin
      @(posedge clk); n++; @(negedge clk);
    end while (!a_valid && n < 40);
    chk("valid_seen", 32'(a_valid), 32'd1);
    chk("sb_depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("res_fix",   32'(a_fix),   32'(e.fix));
      chk("res_bug",   32'(a_bug),   32'(e.bug));
      chk("res_tmo",   32'(a_tmo),   32'(e.tmo));
      chk("res_iter",  32'(a_iter),  32'(e.iter));
      chk("res_state", 32'(a_state), 32'(e.st));
      chk("latency",   32'(n),       32'(e.iter + 1));
      chk("busy_done", 32'(a_busy),  32'd1);
    end
  endtask

  // With res_ready high the result is visible one cycle, then flags clear.
  task automatic finish_hs();
    @(posedge clk); @(negedge clk);
    chk("hs_valid_low", 32'(a_valid), 32'd0);
    chk("hs_busy_low",  32'(a_busy),  32'd0);
    chk("hs_flags_clr", 32'({a_fix, a_bug, a_tmo}), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    launch(v, 1'b1);
    await_result();
    finish_hs();
  endtask

  task automatic run_b(input vec_t v);
    int n = 0;
    init = v.init; blk = v.blk; inj = v.inj; bad = v.bad; start_b = 1'b1;
    @(posedge clk); @(negedge clk);
    start_b = 1'b0;
    do begin
      @(posedge clk); n++; @(negedge clk);
    end while (!b_valid && n < 40);
    chk("b_valid_seen", 32'(b_valid), 32'd1);
    chk("b_fix",   32'(b_fix),   32'(v.fix));
    chk("b_tmo",   32'(b_tmo),   32'(v.tmo));
    chk("b_bug",   32'(b_bug),   32'(v.bug));
    chk("b_iter",  32'(b_iter),  32'(v.iter));
    chk("b_state", 32'(b_state), 32'(v.st));
    chk("b_latency", 32'(n),     32'(v.iter + 1));
    @(posedge clk); @(negedge clk);
    chk("b_hs_valid_low", 32'(b_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //            init     blk      inj   bad      fix  bug  tmo  iter st
    tbl[0] = '{10'h000, 10'h000, 1'b1, 10'h000, 1'b1, 1'b0, 1'b0, 10, 10'h3FF};
    tbl[1] = '{10'h000, 10'h000, 1'b1, 10'h001, 1'b0, 1'b1, 1'b0, 10, 10'h3FF};
    tbl[2] = '{10'h000, 10'h020, 1'b1, 10'h000, 1'b1, 1'b0, 1'b0,  4, 10'h3C0};
    tbl[3] = '{10'h3FF, 10'h000, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0,  0, 10'h3FF};
    tbl[4] = '{10'h3FF, 10'h000, 1'b1, 10'h200, 1'b0, 1'b1, 1'b0,  0, 10'h3FF};
    tbl[5] = '{10'h000, 10'h000, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0,  0, 10'h000};
    tbl[6] = '{10'h001, 10'h000, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0,  0, 10'h001};
    tbl[7] = '{10'h200, 10'h000, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0,  9, 10'h3FF};
    tbl[8] = '{10'h010, 10'h3FF, 1'b1, 10'h000, 1'b1, 1'b0, 1'b0,  0, 10'h010};
    tbl[9] = '{10'h200, 10'h000, 1'b0, 10'h004, 1'b0, 1'b1, 1'b0,  7, 10'h3FC};

    rst_n = 1'b0; start = 1'b0; start_b = 1'b0; res_ready = 1'b1;
    init = '0; blk = '0; inj = 1'b0; bad = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(a_busy),  32'd0);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_flags", 32'({a_fix, a_bug, a_tmo}), 32'd0);
    chk("rst_iter",  32'(a_iter),  32'd0);
    chk("rst_state", 32'(a_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(tbl[i]);

    for (int i = 0; i < 6; i++) begin
      v.init = W'($urandom) & W'($urandom);
      v.blk  = W'($urandom) & W'($urandom);
      v.inj  = 1'($urandom);
      v.bad  = ($urandom_range(0, 3) == 0) ? W'(1 << $urandom_range(0, W - 1)) : '0;
      v = model(v, MI);
      run_vec(v);
    end

    // Timeout at MAX_ITER=4, and fix winning over timeout at iter==MAX_ITER.
    run_b('{10'h000, 10'h000, 1'b1, 10'h000, 1'b0, 1'b0, 1'b1, 4, 10'h3C0});
    run_b('{10'h000, 10'h020, 1'b1, 10'h000, 1'b1, 1'b0, 1'b0, 4, 10'h3C0});

    // Backpressure: result held, start ignored while in DONE.
    res_ready = 1'b0;
    launch(tbl[2], 1'b1);
    await_result();
    for (int k = 0; k < 3; k++) begin
      init = 10'h3FF; start = (k == 1);
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      chk("bp_valid", 32'(a_valid), 32'd1);
      chk("bp_fix",   32'(a_fix),   32'd1);
      chk("bp_iter",  32'(a_iter),  32'd4);
      chk("bp_state", 32'(a_state), 32'h3C0);
    end
    res_ready = 1'b1;
    finish_hs();
    @(posedge clk); @(negedge clk);
    chk("bp_start_dropped", 32'(a_busy), 32'd0);
    run_vec(tbl[7]);

    // Asynchronous reset in the middle of an evaluation.
    launch(tbl[0], 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_iter", 32'(a_iter), 32'd3);
    chk("mid_busy", 32'(a_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",  32'(a_busy),  32'd0);
    chk("arst_valid", 32'(a_valid), 32'd0);
    chk("arst_iter",  32'(a_iter),  32'd0);
    chk("arst_state", 32'(a_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(a_valid), 32'd0);
    run_vec(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
